// File: rtl/dmem_port_arbiter.sv
// Shares the single DataMemoryManager port between the CPU data port and an external
// streaming master: CPU priority, starvation forcing, bounded external bursts.
module dmem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned BURST_MAX    = 8,
   parameter logic [31:0] DATA_TOP     = 32'd4095
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   output logic        cpu_gnt_o,
   output logic        cpu_rvalid_o,
   output logic [31:0] cpu_rdata_o,
   input  logic        ext_req_i,
   input  logic        ext_we_i,
   input  logic [31:0] ext_addr_i,
   input  logic [31:0] ext_wdata_i,
   output logic        ext_gnt_o,
   output logic        ext_rvalid_o,
   output logic [31:0] ext_rdata_o,
   output logic        ext_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_we_o,
   input  logic [31:0] mem_rdata_i
);

   localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int BURST_W = $clog2(BURST_MAX + 1);
   localparam logic [WAIT_W-1:0]  WAIT_SAT  = WAIT_W'(STARVE_LIMIT);
   localparam logic [BURST_W-1:0] BURST_SAT = BURST_W'(BURST_MAX);

   typedef enum logic [1:0] {S_IDLE, S_CPU, S_EXT} state_t;

   state_t               state, state_nxt;
   logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
   logic [BURST_W-1:0]   burst_cnt, burst_nxt;
   logic [31:0]          addr_hold, wdata_hold;
   logic                 rd_cpu, rd_ext;
   logic                 gnt_cpu, gnt_ext, ext_blocked;

   // Grants are suppressed while reset is held so every output reads zero during reset.
   always_comb begin
      gnt_cpu = 1'b0;
      gnt_ext = 1'b0;
      if (!RST) begin
         if (ext_req_i && wait_cnt == WAIT_SAT)
            gnt_ext = 1'b1;
         else if (state == S_EXT && ext_req_i && (!cpu_req_i || burst_cnt < BURST_SAT))
            gnt_ext = 1'b1;
         else if (cpu_req_i)
            gnt_cpu = 1'b1;
         else if (ext_req_i)
            gnt_ext = 1'b1;
      end

      ext_blocked = gnt_ext && ext_we_i && (ext_addr_i <= DATA_TOP);

      state_nxt = S_IDLE;
      if (gnt_cpu)
         state_nxt = S_CPU;
      else if (gnt_ext)
         state_nxt = S_EXT;

      wait_nxt = '0;
      if (ext_req_i && !gnt_ext)
         wait_nxt = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + WAIT_W'(1);

      burst_nxt = '0;
      if (gnt_ext)
         burst_nxt = (burst_cnt == BURST_SAT) ? burst_cnt : burst_cnt + BURST_W'(1);

      // Without a grant the memory bus keeps the last address/data it carried.
      mem_addr_o  = addr_hold;
      mem_wdata_o = wdata_hold;
      if (gnt_cpu) begin
         mem_addr_o  = cpu_addr_i;
         mem_wdata_o = cpu_wdata_i;
      end else if (gnt_ext) begin
         mem_addr_o  = ext_addr_i;
         mem_wdata_o = ext_wdata_i;
      end
      mem_we_o = (gnt_cpu && cpu_we_i) || (gnt_ext && ext_we_i && !ext_blocked);

      cpu_gnt_o    = gnt_cpu;
      ext_gnt_o    = gnt_ext;
      ext_err_o    = ext_blocked;
      cpu_rvalid_o = rd_cpu;
      ext_rvalid_o = rd_ext;
      cpu_rdata_o  = rd_cpu ? mem_rdata_i : '0;
      ext_rdata_o  = rd_ext ? mem_rdata_i : '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         burst_cnt  <= '0;
         addr_hold  <= '0;
         wdata_hold <= '0;
         rd_cpu     <= 1'b0;
         rd_ext     <= 1'b0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_nxt;
         burst_cnt  <= burst_nxt;
         addr_hold  <= mem_addr_o;
         wdata_hold <= mem_wdata_o;
         rd_cpu     <= gnt_cpu && !cpu_we_i;
         rd_ext     <= gnt_ext && !ext_we_i;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, corner sequences and random
// traffic checked against a rule-level arbitration and memory model.
module tb_dmem_port_arbiter;

   localparam int          STARVE = 4;
   localparam int          BURST  = 8;
   localparam logic [31:0] TOP    = 32'd4095;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cpu_req_i, cpu_we_i, ext_req_i, ext_we_i;
   logic [31:0] cpu_addr_i, cpu_wdata_i, ext_addr_i, ext_wdata_i, mem_rdata_i;
   logic        cpu_gnt_o, cpu_rvalid_o, ext_gnt_o, ext_rvalid_o, ext_err_o, mem_we_o;
   logic [31:0] cpu_rdata_o, ext_rdata_o, mem_addr_o, mem_wdata_o;

   dmem_port_arbiter dut (
      .CLK(CLK), .RST(RST),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
      .cpu_rdata_o(cpu_rdata_o),
      .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
      .ext_wdata_i(ext_wdata_i), .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o),
      .ext_rdata_o(ext_rdata_o), .ext_err_o(ext_err_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic cr; logic cw; logic [31:0] ca; logic [31:0] cd;
      logic er; logic ew; logic [31:0] ea; logic [31:0] ed;
   } stim_t;

   typedef struct {
      stim_t s;
      logic cg; logic eg; logic we; logic err; logic crv; logic erv;
      logic [31:0] addr; logic [31:0] crd; logic [31:0] erd;
   } vec_t;

   function automatic int idx_of(input logic [31:0] a);
      return (int'(a[18]) << 13) | int'(a[12:0]);
   endfunction

   function automatic logic [31:0] fill_of(input logic [31:0] a);
      return {18'h25A5A, a[18], a[12:0]};
   endfunction

   // Environment memory answering the DUT one cycle after the address.
   bit          env_written [16384];
   logic [31:0] env_data    [16384];
   always @(posedge CLK) begin
      mem_rdata_i <= env_written[idx_of(mem_addr_o)] ? env_data[idx_of(mem_addr_o)]
                                                     : fill_of(mem_addr_o);
      if (mem_we_o) begin
         env_written[idx_of(mem_addr_o)] <= 1'b1;
         env_data[idx_of(mem_addr_o)]    <= mem_wdata_o;
      end
   end

   // Reference model: owner codes 0 none, 1 cpu, 2 ext.
   int          m_prev, m_waited, m_streak, m_owner, m_pend;
   logic [31:0] m_last_addr, m_last_wdata, m_pend_data;
   bit          ref_written [16384];
   logic [31:0] ref_data    [16384];
   int          total = 0;
   int          bad = 0;

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_written[idx_of(a)] ? ref_data[idx_of(a)] : fill_of(a);
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev = 0; m_waited = 0; m_streak = 0; m_owner = 0; m_pend = 0;
      m_last_addr = '0; m_last_wdata = '0; m_pend_data = '0;
   endtask

   task automatic model_step(input bit chk);
      int owner;
      logic [31:0] ea, ewd;
      if (ext_req_i && m_waited >= STARVE) owner = 2;
      else if (m_prev == 2 && ext_req_i && (!cpu_req_i || m_streak < BURST)) owner = 2;
      else if (cpu_req_i) owner = 1;
      else if (ext_req_i) owner = 2;
      else owner = 0;
      ea  = (owner == 1) ? cpu_addr_i  : (owner == 2) ? ext_addr_i  : m_last_addr;
      ewd = (owner == 1) ? cpu_wdata_i : (owner == 2) ? ext_wdata_i : m_last_wdata;
      if (chk) begin
         check_val("cpu_gnt", cpu_gnt_o, owner == 1);
         check_val("ext_gnt", ext_gnt_o, owner == 2);
         check_val("mem_addr", mem_addr_o, ea);
         check_val("mem_wdata", mem_wdata_o, ewd);
         check_val("mem_we", mem_we_o,
                   (owner == 1 && cpu_we_i) || (owner == 2 && ext_we_i && ext_addr_i > TOP));
         check_val("ext_err", ext_err_o, owner == 2 && ext_we_i && ext_addr_i <= TOP);
         check_val("cpu_rvalid", cpu_rvalid_o, m_pend == 1);
         check_val("ext_rvalid", ext_rvalid_o, m_pend == 2);
         check_val("cpu_rdata", cpu_rdata_o, (m_pend == 1) ? m_pend_data : 32'd0);
         check_val("ext_rdata", ext_rdata_o, (m_pend == 2) ? m_pend_data : 32'd0);
      end
      m_pend = 0;
      if (owner == 1 && !cpu_we_i) m_pend = 1;
      if (owner == 2 && !ext_we_i) m_pend = 2;
      m_pend_data = ref_read(ea);
      if ((owner == 1 && cpu_we_i) || (owner == 2 && ext_we_i && ext_addr_i > TOP)) begin
         ref_written[idx_of(ea)] = 1'b1;
         ref_data[idx_of(ea)]    = ewd;
      end
      m_waited = (owner == 2 || !ext_req_i) ? 0 : ((m_waited < STARVE) ? m_waited + 1 : m_waited);
      m_streak = (owner == 2) ? ((m_streak < BURST) ? m_streak + 1 : m_streak) : 0;
      m_prev = owner;
      m_owner = owner;
      m_last_addr = ea;
      m_last_wdata = ewd;
   endtask

   task automatic applyStimulus(input stim_t s);
      @(negedge CLK);
      cpu_req_i = s.cr; cpu_we_i = s.cw; cpu_addr_i = s.ca; cpu_wdata_i = s.cd;
      ext_req_i = s.er; ext_we_i = s.ew; ext_addr_i = s.ea; ext_wdata_i = s.ed;
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int n);
      string t;
      t = $sformatf("vec%0d", n);
      check_val({t, "_cpu_gnt"}, cpu_gnt_o, v.cg);
      check_val({t, "_ext_gnt"}, ext_gnt_o, v.eg);
      check_val({t, "_mem_we"}, mem_we_o, v.we);
      check_val({t, "_ext_err"}, ext_err_o, v.err);
      check_val({t, "_mem_addr"}, mem_addr_o, v.addr);
      check_val({t, "_cpu_rvalid"}, cpu_rvalid_o, v.crv);
      check_val({t, "_ext_rvalid"}, ext_rvalid_o, v.erv);
      check_val({t, "_cpu_rdata"}, cpu_rdata_o, v.crd);
      check_val({t, "_ext_rdata"}, ext_rdata_o, v.erd);
   endtask

   task automatic step(input stim_t s);
      applyStimulus(s);
      model_step(1'b1);
   endtask

   task automatic zero_inputs();
      cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
      ext_req_i = 0; ext_we_i = 0; ext_addr_i = '0; ext_wdata_i = '0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      zero_inputs();
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      #1;
      model_step(1'b1);
   endtask

   function automatic logic [31:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) return 32'($urandom_range(0, 63) * 4);
      if (r == 4) return 32'd4095;
      if (r == 5) return 32'd4096;
      return 32'd262144 + 32'($urandom_range(0, 63) * 4);
   endfunction

   function automatic stim_t mk(input logic cr, input logic cw, input logic [31:0] ca,
                                input logic [31:0] cd, input logic er, input logic ew,
                                input logic [31:0] ea, input logic [31:0] ed);
      stim_t s;
      s.cr = cr; s.cw = cw; s.ca = ca; s.cd = cd;
      s.er = er; s.ew = ew; s.ea = ea; s.ed = ed;
      return s;
   endfunction

   function automatic vec_t mv(input stim_t s, input logic cg, input logic eg, input logic we,
                               input logic err, input logic [31:0] addr, input logic crv,
                               input logic [31:0] crd, input logic erv, input logic [31:0] erd);
      vec_t v;
      v.s = s; v.cg = cg; v.eg = eg; v.we = we; v.err = err; v.addr = addr;
      v.crv = crv; v.crd = crd; v.erv = erv; v.erd = erd;
      return v;
   endfunction

   vec_t  table_v [13];
   stim_t idle_s;

   initial begin
      stim_t cur, s;
      int first_ext, cpu_after, cpu_first, beats, cycles;

      RST = 1'b1;
      zero_inputs();
      model_reset();
      idle_s = mk(0, 0, 0, 0, 0, 0, 0, 0);

      // Outputs while reset is asserted from time zero.
      #1;
      check_val("rst_cpu_gnt", cpu_gnt_o, 1'b0);
      check_val("rst_mem_we", mem_we_o, 1'b0);
      check_val("rst_mem_addr", mem_addr_o, 32'd0);
      check_val("rst_cpu_rvalid", cpu_rvalid_o, 1'b0);
      do_reset();

      table_v[0]  = mv(mk(1, 1, 100, 32'hDEAD, 0, 0, 0, 0), 1, 0, 1, 0, 100, 0, 0, 0, 0);
      table_v[1]  = mv(mk(1, 0, 100, 32'hDEAD, 0, 0, 0, 0), 1, 0, 0, 0, 100, 0, 0, 0, 0);
      table_v[2]  = mv(idle_s, 0, 0, 0, 0, 100, 1, 32'hDEAD, 0, 0);
      table_v[3]  = mv(mk(0, 0, 0, 0, 1, 1, 4095, 32'h1111), 0, 1, 0, 1, 4095, 0, 0, 0, 0);
      table_v[4]  = mv(mk(0, 0, 0, 0, 1, 1, 262144, 32'h2222), 0, 1, 1, 0, 262144, 0, 0, 0, 0);
      table_v[5]  = mv(mk(1, 0, 8, 0, 0, 0, 0, 0), 1, 0, 0, 0, 8, 0, 0, 0, 0);
      table_v[6]  = mv(mk(0, 0, 0, 0, 1, 0, 262148, 0), 0, 1, 0, 0, 262148, 1, fill_of(8), 0, 0);
      table_v[7]  = mv(idle_s, 0, 0, 0, 0, 262148, 0, 0, 1, fill_of(262148));
      table_v[8]  = mv(mk(0, 0, 0, 0, 1, 0, 262144, 0), 0, 1, 0, 0, 262144, 0, 0, 0, 0);
      table_v[9]  = mv(mk(0, 0, 0, 0, 1, 0, 4095, 0), 0, 1, 0, 0, 4095, 0, 0, 1, 32'h2222);
      table_v[10] = mv(idle_s, 0, 0, 0, 0, 4095, 0, 0, 1, fill_of(4095));
      table_v[11] = mv(mk(1, 0, 200, 0, 1, 0, 262152, 0), 1, 0, 0, 0, 200, 0, 0, 0, 0);
      table_v[12] = mv(idle_s, 0, 0, 0, 0, 200, 1, fill_of(200), 0, 0);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(table_v[i].s);
         checkOutput(table_v[i], i);
         model_step(1'b0);
      end

      // Both requesters held: forced external grant, then a full burst before the CPU returns.
      do_reset();
      first_ext = -1;
      cpu_after = -1;
      s = mk(1, 0, 8, 0, 1, 0, 262148, 0);
      for (int c = 0; c < 30; c++) begin
         step(s);
         if (ext_gnt_o && first_ext < 0) first_ext = c;
         if (cpu_gnt_o && first_ext >= 0 && cpu_after < 0) cpu_after = c;
      end
      check_val("starve_first_ext", first_ext, 4);
      check_val("burst_cpu_return", cpu_after, 12);

      // External read stream of 20 beats with the CPU raising a request at beat 3.
      do_reset();
      beats = 0;
      cpu_first = -1;
      cycles = 0;
      for (int c = 0; c < 30 && beats < 20; c++) begin
         s = mk((c >= 3) && (cpu_first < 0), 0, 16, 0, 1, 0, 32'd262144 + 32'(beats * 4), 0);
         step(s);
         cycles++;
         if (ext_gnt_o) beats++;
         if (cpu_gnt_o && cpu_first < 0) cpu_first = c;
      end
      check_val("stream_beats", beats, 20);
      check_val("stream_cpu_cycle", cpu_first, 8);
      check_val("stream_cycles", cycles, 21);

      // Long solo burst: the counter must stay saturated, so the CPU wins at once.
      do_reset();
      for (int c = 0; c < 17; c++) step(mk(0, 0, 0, 0, 1, 0, 32'd262144 + 32'(c * 4), 0));
      step(mk(1, 0, 24, 0, 1, 0, 32'd262400, 0));
      check_val("sat_cpu_gnt", cpu_gnt_o, 1'b1);
      step(idle_s);

      // Reset pulsed while a read response is pending.
      do_reset();
      step(mk(1, 0, 100, 0, 0, 0, 0, 0));
      @(negedge CLK);
      RST = 1'b1;
      cpu_req_i = 1; cpu_addr_i = 8; ext_req_i = 1; ext_we_i = 1; ext_addr_i = 262144;
      ext_wdata_i = 32'h7777;
      #1;
      check_val("midrst_cpu_rvalid", cpu_rvalid_o, 1'b0);
      check_val("midrst_cpu_rdata", cpu_rdata_o, 32'd0);
      check_val("midrst_cpu_gnt", cpu_gnt_o, 1'b0);
      check_val("midrst_ext_gnt", ext_gnt_o, 1'b0);
      check_val("midrst_mem_we", mem_we_o, 1'b0);
      check_val("midrst_mem_addr", mem_addr_o, 32'd0);
      check_val("midrst_mem_wdata", mem_wdata_o, 32'd0);
      check_val("midrst_ext_err", ext_err_o, 1'b0);
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
      zero_inputs();
      #1;
      model_step(1'b1);
      step(mk(1, 0, 12, 0, 1, 0, 262160, 0));
      check_val("post_rst_cpu_first", cpu_gnt_o, 1'b1);
      step(idle_s);

      // Random traffic; each requester holds its fields until granted or dropped.
      do_reset();
      cur = idle_s;
      for (int c = 0; c < 600; c++) begin
         if (!cur.cr || m_owner == 1) begin
            cur.cr = ($urandom_range(0, 9) < 6);
            cur.cw = 1'($urandom_range(0, 1));
            cur.ca = pick_addr();
            cur.cd = $urandom();
         end else if ($urandom_range(0, 9) == 0) begin
            cur.cr = 1'b0;
         end
         if (!cur.er || m_owner == 2) begin
            cur.er = ($urandom_range(0, 9) < 5);
            cur.ew = 1'($urandom_range(0, 1));
            cur.ea = pick_addr();
            cur.ed = $urandom();
         end else if ($urandom_range(0, 9) == 0) begin
            cur.er = 1'b0;
         end
         step(cur);
      end
      step(idle_s);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
